// File: rtl/precv_buf_if.sv
// ============================================================================
//  Module   : precv_buf_if
//  Brief    : Link-side write bus and AXI-Stream payload bus of precv_buf.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface precv_buf_if;
    logic [63:0] sfp_wr_data;
    logic        sfp_wr_en;
    logic [31:0] axis_data;
    logic        axis_valid;
    logic        axis_ready;

    // master: link source plus downstream consumer; slave: the receive buffer
    modport master (
        output sfp_wr_data, sfp_wr_en, axis_ready,
        input  axis_data, axis_valid
    );
    modport slave (
        input  sfp_wr_data, sfp_wr_en, axis_ready,
        output axis_data, axis_valid
    );
endinterface

`default_nettype wire

// File: rtl/precv_buf.sv
// ============================================================================
//  Module   : precv_buf
//  Brief    : Receive buffer: checks/strips the link marker, queues payloads
//             and streams them out with credit return. Optional marker check
//             enabled by defining PRECV_BUF_MARKER_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module precv_buf #(
    parameter int          ADDR_W = 10,
    parameter logic [31:0] MARKER = 32'h55aa55bc
) (
    input  wire logic        ap_clk,
    input  wire logic        ap_rst,
    precv_buf_if.slave       bus,
    output logic [31:0]      recv_buff_statue,
    output logic [31:0]      recv_words,
    output logic [15:0]      err_cnt,
    output logic [15:0]      ovf_cnt,
    output logic             credit_ret,
    output logic             buf_nonempty
);

    localparam int                c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   c_OCC_FULL = (ADDR_W+1)'(c_DEPTH);
    localparam logic [15:0]       c_SAT      = 16'hFFFF;

    logic [31:0]       r_mem [0:c_DEPTH-1];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_occ;
    logic [31:0]       r_axis_data;
    logic              r_axis_valid;
    logic [31:0]       r_recv_words;
    logic [15:0]       r_ovf_cnt;
    logic              r_credit;

    logic w_full;
    logic w_fifo_nonempty;
    logic w_hs;
    logic w_pop;
    logic w_marker_ok;
    logic w_push;
    logic w_ovf;

`ifdef PRECV_BUF_MARKER_CHECK_EN
    logic [15:0] r_err_cnt;
    logic        w_bad;

    assign w_marker_ok = (bus.sfp_wr_data[31:0] == MARKER);
    assign w_bad       = bus.sfp_wr_en & ~w_marker_ok;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_err_cnt <= '0;
        end else if (w_bad && r_err_cnt != c_SAT) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_marker_unused;

    // Marker half of the link word is ignored when checking is compiled out
    assign w_marker_unused = ^{bus.sfp_wr_data[31:0], MARKER};
    assign w_marker_ok     = 1'b1;
    assign err_cnt         = '0;
`endif

    assign w_full          = (r_occ == c_OCC_FULL);
    assign w_fifo_nonempty = (r_occ != '0);
    assign w_hs            = r_axis_valid & bus.axis_ready;
    assign w_pop           = w_fifo_nonempty & (~r_axis_valid | bus.axis_ready);
    // A full FIFO still takes the word when the head leaves in the same cycle
    assign w_push          = bus.sfp_wr_en & w_marker_ok & (~w_full | w_pop);
    assign w_ovf           = bus.sfp_wr_en & w_marker_ok & w_full & ~w_pop;

    // Storage carries no reset; validity is tracked by pointers and occupancy
    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.sfp_wr_data[63:32];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_axis_data  <= '0;
            r_axis_valid <= 1'b0;
            r_recv_words <= '0;
            r_ovf_cnt    <= '0;
            r_credit     <= 1'b0;
        end else begin
            r_credit <= w_hs;

            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_recv_words <= r_recv_words + 32'd1;
            end

            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_axis_data  <= r_mem[r_rd_ptr];
                r_axis_valid <= 1'b1;
            end else if (w_hs) begin
                r_axis_valid <= 1'b0;
            end

            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase

            if (w_ovf && r_ovf_cnt != c_SAT) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign bus.axis_data    = r_axis_data;
    assign bus.axis_valid   = r_axis_valid;
    assign recv_buff_statue = 32'(c_DEPTH) - 32'(r_occ);
    assign recv_words       = r_recv_words;
    assign ovf_cnt          = r_ovf_cnt;
    assign credit_ret       = r_credit;
    assign buf_nonempty     = w_fifo_nonempty | r_axis_valid;

endmodule

`default_nettype wire

// File: tb/tb_precv_buf.sv
// ============================================================================
//  Module   : tb_precv_buf
//  Brief    : Directed bench for precv_buf with a scoreboard-driven monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_precv_buf;

    localparam logic [31:0] c_MARKER = 32'h55aa55bc;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [31:0] recv_buff_statue;
    logic [31:0] recv_words;
    logic [15:0] err_cnt;
    logic [15:0] ovf_cnt;
    logic        credit_ret;
    logic        buf_nonempty;

    precv_buf_if bus ();

    precv_buf #(.ADDR_W(10), .MARKER(c_MARKER)) dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .bus              (bus),
        .recv_buff_statue (recv_buff_statue),
        .recv_words       (recv_words),
        .err_cnt          (err_cnt),
        .ovf_cnt          (ovf_cnt),
        .credit_ret       (credit_ret),
        .buf_nonempty     (buf_nonempty)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cred_cnt = 0;
    int          exp_ovf  = 0;
    logic [31:0] sb [$];
    logic        prev_hs    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: credit pulse follows each handshake, stall holds the output,
    // every handshake must match the head of the scoreboard.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            prev_hs    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("credit_ret", {31'b0, credit_ret}, {31'b0, prev_hs});
            if (credit_ret) cred_cnt++;
            if (prev_stall) begin
                check("stall_valid", {31'b0, bus.axis_valid}, 32'd1);
                check("stall_data", bus.axis_data, prev_data);
            end
            if (bus.axis_valid && bus.axis_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected no output", bus.axis_data);
                end else begin
                    check("payload", bus.axis_data, sb.pop_front());
                end
            end
            prev_hs    = bus.axis_valid & bus.axis_ready;
            prev_stall = bus.axis_valid & ~bus.axis_ready;
            prev_data  = bus.axis_data;
        end
    end

    task automatic drive(input logic [31:0] pay, input logic [31:0] mk);
        bus.sfp_wr_data = {pay, mk};
        bus.sfp_wr_en   = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.sfp_wr_en   = 1'b0;
    endtask

    task automatic send_good(input logic [31:0] pay);
        sb.push_back(pay);
        drive(pay, c_MARKER);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        sb.delete();
        tick(1);
        ap_rst   = 1'b0;
        cred_cnt = 0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 5000) begin
            @(posedge ap_clk);
            k++;
        end
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d payloads pending, expected 0", name, sb.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sfp_wr_data = '0;
        bus.sfp_wr_en   = 1'b0;
        bus.axis_ready  = 1'b0;
        ap_rst          = 1'b1;
        tick(3);
        ap_rst = 1'b0;

        // Reset values
        check("rst_valid", {31'b0, bus.axis_valid}, 32'd0);
        check("rst_data", bus.axis_data, 32'd0);
        check("rst_credit", {31'b0, credit_ret}, 32'd0);
        check("rst_statue", recv_buff_statue, 32'd1024);
        check("rst_words", recv_words, 32'd0);
        check("rst_err", {16'b0, err_cnt}, 32'd0);
        check("rst_ovf", {16'b0, ovf_cnt}, 32'd0);
        check("rst_nonempty", {31'b0, buf_nonempty}, 32'd0);

        // Four back-to-back words, payload k shows up in cycle k+1
        bus.axis_ready = 1'b1;
        cred_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                sb.push_back(32'(k + 1));
                bus.sfp_wr_data = {32'(k + 1), c_MARKER};
                bus.sfp_wr_en   = 1'b1;
            end
            @(posedge ap_clk);
            #1;
            bus.sfp_wr_en = 1'b0;
            if (k >= 1) begin
                check("lat_valid", {31'b0, bus.axis_valid}, 32'd1);
                check("lat_data", bus.axis_data, 32'(k));
            end
        end
        tick(3);
        check("b2b_credits", 32'(cred_cnt), 32'd4);
        check("b2b_words", recv_words, 32'd4);
        check("b2b_statue", recv_buff_statue, 32'd1024);
        check("b2b_nonempty", {31'b0, buf_nonempty}, 32'd0);

        // Marker mismatch
        do_reset();
        bus.axis_ready = 1'b1;
`ifdef PRECV_BUF_MARKER_CHECK_EN
        drive(32'hDEAD0000, 32'h0);
        tick(3);
        check("bad_err", {16'b0, err_cnt}, 32'd1);
        check("bad_words", recv_words, 32'd0);
        check("bad_valid", {31'b0, bus.axis_valid}, 32'd0);
        check("bad_nonempty", {31'b0, buf_nonempty}, 32'd0);
`else
        sb.push_back(32'hDEAD0000);
        drive(32'hDEAD0000, 32'h0);
        tick(3);
        check("nochk_err", {16'b0, err_cnt}, 32'd0);
        check("nochk_words", recv_words, 32'd1);
        check("nochk_pending", 32'(sb.size()), 32'd0);
`endif

        // Fill: output register + 1024 FIFO entries, 1026th word overflows
        do_reset();
        bus.axis_ready = 1'b0;
        for (int i = 0; i < 1026; i++) begin
            if (i < 1025) send_good(32'(i + 1));
            else          drive(32'(i + 1), c_MARKER);
        end
        tick(2);
        exp_ovf = 1;
        check("full_statue", recv_buff_statue, 32'd0);
        check("full_ovf", {16'b0, ovf_cnt}, 32'(exp_ovf));
        check("full_words", recv_words, 32'd1025);
        check("full_data", bus.axis_data, 32'd1);
        check("full_nonempty", {31'b0, buf_nonempty}, 32'd1);

        // Bad marker into a full FIFO
        drive(32'hBAD00000, 32'h0);
        tick(1);
`ifdef PRECV_BUF_MARKER_CHECK_EN
        check("full_bad_err", {16'b0, err_cnt}, 32'd1);
`else
        exp_ovf = 2;
`endif
        check("full_bad_ovf", {16'b0, ovf_cnt}, 32'(exp_ovf));

        // Full FIFO, write and pop in the same cycle
        bus.axis_ready = 1'b1;
        send_good(32'hABCD0001);
        bus.axis_ready = 1'b0;
        tick(1);
        check("simul_ovf", {16'b0, ovf_cnt}, 32'(exp_ovf));
        check("simul_statue", recv_buff_statue, 32'd0);
        check("simul_words", recv_words, 32'd1026);
        check("simul_data", bus.axis_data, 32'd2);

        bus.axis_ready = 1'b1;
        wait_drain("full_drain");
        tick(3);
        check("full_credits", 32'(cred_cnt), 32'd1026);
        check("drain_statue", recv_buff_statue, 32'd1024);
        check("drain_nonempty", {31'b0, buf_nonempty}, 32'd0);

        // Long stream with toggling ready; wraps both pointers
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            bus.axis_ready = (i % 2 == 0);
            send_good(32'h10000000 + 32'(i));
        end
        bus.axis_ready = 1'b1;
        wait_drain("toggle_drain");
        tick(3);
        check("toggle_credits", 32'(cred_cnt), 32'd2000);
        check("toggle_words", recv_words, 32'd2000);
        check("toggle_ovf", {16'b0, ovf_cnt}, 32'd0);
        check("toggle_statue", recv_buff_statue, 32'd1024);

        // Reset with data queued
        bus.axis_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_good(32'h20000000 + 32'(i));
        ap_rst = 1'b1;
        sb.delete();
        tick(1);
        ap_rst = 1'b0;
        check("mrst_valid", {31'b0, bus.axis_valid}, 32'd0);
        check("mrst_statue", recv_buff_statue, 32'd1024);
        check("mrst_nonempty", {31'b0, buf_nonempty}, 32'd0);
        check("mrst_words", recv_words, 32'd0);

        bus.axis_ready = 1'b1;
        sb.push_back(32'h00007777);
        bus.sfp_wr_data = {32'h00007777, c_MARKER};
        bus.sfp_wr_en   = 1'b1;
        tick(1);
        bus.sfp_wr_en = 1'b0;
        check("post_rst_c1_valid", {31'b0, bus.axis_valid}, 32'd0);
        tick(1);
        check("post_rst_c2_valid", {31'b0, bus.axis_valid}, 32'd1);
        check("post_rst_c2_data", bus.axis_data, 32'h00007777);
        tick(3);
        check("post_rst_pending", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/precv_buf.md
# precv_buf

Receive-side buffer of the PCIe kernel link: accepts 64-bit words from the SFP interface, validates and strips the 32-bit marker in the low half, queues the 32-bit payload and presents it on an AXI-Stream master. It is the far end of the transmit buffer that tags each 32-bit payload with marker 32'h55aa55bc. Each payload consumed downstream returns one credit to the transmitter, and free space, error and overflow counts are exported to the register block.

## Interface

- ADDR_W, 10, FIFO address width; DEPTH = 2^ADDR_W entries (1024 = transmitter credit count).
- MARKER, 32'h55aa55bc, required value of sfp_wr_data[31:0].

- ap_clk  in  1  single clock; all logic rising-edge.
- ap_rst  in  1  synchronous, active-high reset.
- sfp_wr_data  in  64  link word; [63:32] payload, [31:0] marker.
- sfp_wr_en  in  1  word valid this cycle; no backpressure to the link.
- axis_data  out  32  payload, registered.
- axis_valid  out  1  axis_data valid.
- axis_ready  in  1  downstream accept.
- recv_buff_statue  out  32  free FIFO entries = DEPTH - occupancy.
- recv_words  out  32  accepted-word counter, wraps modulo 2^32.
- err_cnt  out  16  marker-mismatch drops, saturates at 16'hFFFF.
- ovf_cnt  out  16  full-FIFO drops, saturates at 16'hFFFF.
- credit_ret  out  1  one-cycle pulse per consumed payload.
- buf_nonempty  out  1  FIFO or output register holds data.

## Operation

- Accept condition: sfp_wr_en=1, marker matches, and FIFO not full, or FIFO full with a pop to the output register in the same cycle.
- On accept: write sfp_wr_data[63:32] at wr_ptr, wr_ptr+1 (wraps at DEPTH), recv_words+1.
- Marker mismatch (with check enabled): word dropped, err_cnt+1. This takes priority over the overflow check, so a bad word to a full FIFO increments only err_cnt.
- Full and no same-cycle pop: word dropped, ovf_cnt+1.
- Storage: register array, DEPTH entries, combinational read at rd_ptr. Occupancy counter is ADDR_W+1 bits, range 0..DEPTH.
- Output stage: a single register.
  - Load from FIFO head when FIFO is non-empty and (axis_valid=0 or axis_valid&axis_ready=1).
  - A load pops the FIFO: rd_ptr+1 (wraps at DEPTH), occupancy-1.
  - If a handshake occurs with the FIFO empty, axis_valid goes to 0.
  - While axis_valid=1 and axis_ready=0, axis_data and axis_valid are held stable.
- Simultaneous accept and pop: occupancy unchanged, recv_buff_statue unchanged.
- credit_ret: registered copy of (axis_valid & axis_ready).
- buf_nonempty = (occupancy != 0) | axis_valid; combinational from registers.
- Reset mid-stream: all queued data discarded; pointers, occupancy and output register cleared.

## Timing

- Reset values:
  - axis_data=0, axis_valid=0, credit_ret=0.
  - recv_buff_statue=DEPTH (1024), recv_words=0, err_cnt=0, ovf_cnt=0.
  - buf_nonempty=0; wr_ptr=rd_ptr=0.
- Latency with the output register empty:
  - sfp_wr_en in cycle 0: word enters the FIFO at the end of cycle 0.
  - axis_valid=1 with that payload in cycle 2.
- Throughput: one word per cycle sustained with axis_ready held at 1.
- credit_ret is high in the cycle after each handshake; N handshakes give exactly N pulses.
- recv_buff_statue, recv_words, err_cnt and ovf_cnt update one cycle after the triggering event.

## Configuration

- PRECV_BUF_MARKER_CHECK_EN defined:
  - sfp_wr_data[31:0] is compared with MARKER.
  - Mismatches are dropped and counted in err_cnt.
- Not defined:
  - No comparison; every sfp_wr_en word is a candidate for accept (overflow rule still applies).
  - err_cnt is constant 0.

## Test plan

- Reset, then 4 words {32'h1..32'h4, MARKER} back-to-back, axis_ready=1 -> axis_data 1,2,3,4 in cycles 2..5; 4 credit_ret pulses; recv_words=4; recv_buff_statue returns to 1024.
- Word {32'hDEAD0000, 32'h0} (macro defined) -> no axis_valid, err_cnt=1, recv_words=0. Macro undefined -> payload 32'hDEAD0000 delivered, err_cnt=0.
- axis_ready=0, write 1026 good words:
  - Output register holds 1 word and the FIFO holds 1024.
  - 1026th word dropped; ovf_cnt=1, recv_buff_statue=0.
  - Raise axis_ready -> 1025 payloads delivered in order and 1025 credits returned.
- FIFO full, sfp_wr_en and output-register pop in the same cycle -> word accepted, ovf_cnt unchanged, recv_buff_statue stays 0.
- axis_ready toggling 1,0,1,0 during a 2000-word stream -> axis_data stable while stalled; pointer wrap past 1023 verified by an in-order payload sequence.
- Assert ap_rst with 10 words queued -> next cycle axis_valid=0, recv_buff_statue=1024, buf_nonempty=0; a following good word arrives with 2-cycle latency.
